// File: rtl/dag_pkg.sv
// Shared types for the DAG path-count engine: FSM state encoding and error codes.
// Build option DAG_ACCUM_SAT_EN (used by the queue and top) selects saturating adds.
package dag_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_POP,
    ST_REQ,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_QFULL = 2'd1;
  localparam logic [1:0] ERR_EDGE  = 2'd2;
  localparam logic [1:0] ERR_ACC   = 2'd3;

endpackage

// File: rtl/dag_path_counter_queue.sv
// Merging accumulator FIFO: a push whose node is already queued adds into that entry.
// Macro DAG_ACCUM_SAT_EN: merge adds saturate instead of wrapping.
module dag_accum_queue #(
  parameter int NODE_W  = 10,
  parameter int ACCUM_W = 24,
  parameter int QDEPTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [NODE_W-1:0]       push_node_i,
  input  logic [ACCUM_W-1:0]      push_acc_i,
  input  logic                    pop_i,
  output logic [NODE_W-1:0]       head_node_o,
  output logic [ACCUM_W-1:0]      head_acc_o,
  output logic                    empty_o,
  output logic [$clog2(QDEPTH):0] level_o,
  output logic                    drop_o,
  output logic                    ovf_o
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [NODE_W-1:0]  node;
    logic [ACCUM_W-1:0] acc;
  } q_data_t;

  logic [QDEPTH-1:0] valid_q;
  q_data_t           mem_q [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q;

  logic              full, hit, merge, alloc;
  logic [PTR_W-1:0]  hit_idx;
  logic [ACCUM_W:0]  sum;
  logic [ACCUM_W-1:0] merge_acc;

  assign full        = (wr_ptr_q == rd_ptr_q) && valid_q[rd_ptr_q];
  assign empty_o     = (wr_ptr_q == rd_ptr_q) && !valid_q[rd_ptr_q];
  assign head_node_o = mem_q[rd_ptr_q].node;
  assign head_acc_o  = mem_q[rd_ptr_q].acc;
  assign level_o     = level_q;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = QDEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && (mem_q[i].node == push_node_i)) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  assign sum = {1'b0, mem_q[hit_idx].acc} + {1'b0, push_acc_i};
`ifdef DAG_ACCUM_SAT_EN
  assign merge_acc = sum[ACCUM_W] ? '1 : sum[ACCUM_W-1:0];
`else
  assign merge_acc = sum[ACCUM_W-1:0];
`endif

  assign merge  = push_i && hit;
  assign alloc  = push_i && !hit && !full;
  assign drop_o = push_i && !hit && full;
  assign ovf_o  = merge && sum[ACCUM_W];

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (alloc) begin
      valid_q[wr_ptr_q] <= 1'b1;
      wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      level_q           <= level_q + LVL_W'(1);
    end else if (pop_i && !empty_o) begin
      valid_q[rd_ptr_q] <= 1'b0;
      rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
      level_q           <= level_q - LVL_W'(1);
    end
  end

  // NOTE: payload storage has no reset; an entry is only ever read while its valid bit is set.
  always_ff @(posedge clk) begin
    if (alloc) begin
      mem_q[wr_ptr_q] <= '{node: push_node_i, acc: push_acc_i};
    end else if (merge) begin
      mem_q[hit_idx].acc <= merge_acc;
    end
  end

endmodule

// File: rtl/dag_path_counter.sv
// Breadth-first path counter over an external adjacency memory, one request in flight.
// Macro DAG_ACCUM_SAT_EN: result and merge adds saturate at the maximum count.
module dag_path_counter
  import dag_pkg::*;
#(
  parameter int NODE_W  = 10,
  parameter int EDGE_W  = 4,
  parameter int ACCUM_W = 24,
  parameter int QDEPTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NODE_W-1:0]       start_node,
  input  logic [NODE_W-1:0]       end_node,
  output logic                    adj_req,
  output logic [NODE_W-1:0]       adj_node,
  output logic [EDGE_W-1:0]       adj_edge,
  input  logic                    adj_rsp_valid,
  input  logic                    adj_rsp_none,
  input  logic [NODE_W-1:0]       adj_rsp_dst,
  input  logic                    adj_rsp_last,
  output logic                    busy,
  output logic                    done,
  output logic [ACCUM_W-1:0]      result,
  output logic [1:0]              err,
  output logic [$clog2(QDEPTH):0] qlevel
);

  state_e             state_q, state_d;
  logic [NODE_W-1:0]  start_node_q, start_node_d, end_node_q, end_node_d;
  logic [NODE_W-1:0]  cur_node_q, cur_node_d;
  logic [ACCUM_W-1:0] cur_acc_q, cur_acc_d, result_q, result_d;
  logic [EDGE_W-1:0]  edge_q, edge_d;
  logic               gap_q, gap_d, done_q, done_d;
  logic [1:0]         err_q, err_d;

  logic               q_flush, q_push, q_pop, q_empty, q_drop, q_ovf;
  logic [NODE_W-1:0]  q_push_node, q_head_node;
  logic [ACCUM_W-1:0] q_push_acc, q_head_acc, res_add;
  logic [ACCUM_W:0]   res_sum;

  dag_accum_queue #(.NODE_W(NODE_W), .ACCUM_W(ACCUM_W), .QDEPTH(QDEPTH)) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (q_flush),
    .push_i     (q_push),
    .push_node_i(q_push_node),
    .push_acc_i (q_push_acc),
    .pop_i      (q_pop),
    .head_node_o(q_head_node),
    .head_acc_o (q_head_acc),
    .empty_o    (q_empty),
    .level_o    (qlevel),
    .drop_o     (q_drop),
    .ovf_o      (q_ovf)
  );

  assign res_sum = {1'b0, result_q} + {1'b0, q_head_acc};
`ifdef DAG_ACCUM_SAT_EN
  assign res_add = res_sum[ACCUM_W] ? '1 : res_sum[ACCUM_W-1:0];
`else
  assign res_add = res_sum[ACCUM_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      start_node_q <= '0;
      end_node_q   <= '0;
      cur_node_q   <= '0;
      cur_acc_q    <= '0;
      result_q     <= '0;
      edge_q       <= '0;
      gap_q        <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      start_node_q <= start_node_d;
      end_node_q   <= end_node_d;
      cur_node_q   <= cur_node_d;
      cur_acc_q    <= cur_acc_d;
      result_q     <= result_d;
      edge_q       <= edge_d;
      gap_q        <= gap_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    start_node_d = start_node_q;
    end_node_d   = end_node_q;
    cur_node_d   = cur_node_q;
    cur_acc_d    = cur_acc_q;
    result_d     = result_q;
    edge_d       = edge_q;
    gap_d        = gap_q;
    done_d       = 1'b0;
    err_d        = err_q;
    q_flush      = 1'b0;
    q_push       = 1'b0;
    q_push_node  = adj_rsp_dst;
    q_push_acc   = cur_acc_q;
    q_pop        = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          start_node_d = start_node;
          end_node_d   = end_node;
          result_d     = '0;
          err_d        = ERR_NONE;
          q_flush      = 1'b1;
          state_d      = ST_SEED;
        end
      end
      ST_SEED: begin
        q_push      = 1'b1;
        q_push_node = start_node_q;
        q_push_acc  = ACCUM_W'(1);
        state_d     = ST_POP;
      end
      ST_POP: begin
        if (q_empty) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          q_pop      = 1'b1;
          cur_node_d = q_head_node;
          cur_acc_d  = q_head_acc;
          if (q_head_node == end_node_q) begin
            result_d = res_add;
            if (res_sum[ACCUM_W]) err_d = ERR_ACC;
          end else begin
            edge_d  = '0;
            gap_d   = 1'b0;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (adj_rsp_valid) begin
          if (adj_rsp_none) begin
            state_d = ST_POP;
          end else begin
            q_push = 1'b1;
            if (q_ovf) err_d = ERR_ACC;
            if (q_drop) begin
              err_d   = ERR_QFULL;
              state_d = ST_ERROR;
            end else if (adj_rsp_last) begin
              state_d = ST_POP;
            end else if (edge_q == '1) begin
              err_d   = ERR_EDGE;
              state_d = ST_ERROR;
            end else begin
              edge_d = edge_q + EDGE_W'(1);
              gap_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign adj_req  = (state_q == ST_REQ) && !gap_q;
  assign adj_node = cur_node_q;
  assign adj_edge = edge_q;
  assign busy     = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign done     = done_q;
  assign result   = result_q;
  assign err      = err_q;

endmodule
